// File: rtl/pwm_bank.sv
// N-channel PWM bank: prescaled tick, shared period counter, double-buffered duties
// (shadow written over the register port, active loaded at period end), per-channel polarity.
module pwm_bank #(
  parameter int                  CHANNELS = 8,
  parameter int                  WIDTH    = 8,
  parameter int                  PRESCALE = 1200,
  parameter int                  ADDR_W   = 3,
  parameter logic [CHANNELS-1:0] POLARITY = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [WIDTH-1:0]    rd_data,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_end
);

  localparam int              PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST  = PS_W'(PRESCALE - 1);
  // Last counter value of a period is 2^WIDTH-2, so the period is 2^WIDTH-1 ticks.
  localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

  logic [PS_W-1:0]     presc_r;
  logic [WIDTH-1:0]    cnt_r;
  logic [WIDTH-1:0]    shadow_r [CHANNELS];
  logic [WIDTH-1:0]    active_r [CHANNELS];
  logic                tick_s;
  logic                boundary_s;
  logic [WIDTH-1:0]    rd_mux_s;
  logic [CHANNELS-1:0] pwm_next_s;

  // Tick and period-boundary decode.
  always_comb begin
    tick_s     = 1'b0;
    boundary_s = 1'b0;
    if (enable && (presc_r == PS_LAST)) begin
      tick_s     = 1'b1;
      boundary_s = (cnt_r == CNT_LAST);
    end else begin
      tick_s     = 1'b0;
      boundary_s = 1'b0;
    end
  end

  // Read-back mux; out-of-range addresses match no channel and return zero.
  always_comb begin
    rd_mux_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      rd_mux_s = rd_mux_s | ((rd_addr == ADDR_W'(i)) ? shadow_r[i] : '0);
    end
  end

  // Next PWM level per channel; idle level is the polarity bit.
  always_comb begin
    pwm_next_s = POLARITY;
    for (int i = 0; i < CHANNELS; i++) begin
      if (enable) begin
        pwm_next_s[i] = (cnt_r < active_r[i]) ^ POLARITY[i];
      end else begin
        pwm_next_s[i] = POLARITY[i];
      end
    end
  end

  // Prescaler, period counter and period_end pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_r    <= '0;
      cnt_r      <= '0;
      period_end <= 1'b0;
    end else if (!enable) begin
      presc_r    <= '0;
      cnt_r      <= '0;
      period_end <= 1'b0;
    end else begin
      period_end <= boundary_s;
      if (tick_s) begin
        presc_r <= '0;
        cnt_r   <= boundary_s ? '0 : cnt_r + WIDTH'(1);
      end else begin
        presc_r <= presc_r + PS_W'(1);
      end
    end
  end

  // Duty registers: shadow takes writes; active follows shadow while idle or at a period boundary.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_r[i] <= '0;
        active_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_en && (wr_addr == ADDR_W'(i))) begin
          shadow_r[i] <= wr_data;
        end
        if (!enable || boundary_s) begin
          active_r[i] <= shadow_r[i];
        end
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_out <= POLARITY;
      rd_data <= '0;
    end else begin
      pwm_out <= pwm_next_s;
      rd_data <= rd_mux_s;
    end
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Directed scoreboard bench for pwm_bank: u_a (PRESCALE=1, POLARITY=0) and
// u_b (PRESCALE=4, POLARITY=8'hF0) share all inputs.
module tb_pwm_bank;

  logic       clk = 1'b0;
  logic       rst_n, enable, wr_en;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data_a, rd_data_b, pwm_a, pwm_b;
  logic       pe_a, pe_b;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb [$];

  always #5 clk = ~clk;

  pwm_bank #(.CHANNELS(8), .WIDTH(8), .PRESCALE(1), .ADDR_W(4), .POLARITY(8'h00)) u_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_a), .pwm_out(pwm_a),
    .period_end(pe_a));

  pwm_bank #(.CHANNELS(8), .WIDTH(8), .PRESCALE(4), .ADDR_W(4), .POLARITY(8'hF0)) u_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_b), .pwm_out(pwm_b),
    .period_end(pe_b));

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %0h, no expected value queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic write(input logic [3:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
    rd_addr = a;
    push(tag, {24'd0, exp});
    @(negedge clk);
    pop_chk({24'd0, rd_data_a});
  endtask

  // Count negedges until the selected DUT shows period_end (bounded).
  task automatic wait_pe(input bit sel, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sel ? pe_b : pe_a) && n < limit);
  endtask

  // Sample n cycles: per-channel high counts, period_end count and its value on the last sample.
  task automatic measure(input bit sel, input int n, input int wr_at, input logic [3:0] wa,
                         input logic [7:0] wd, output int hi [8], output int pe_cnt,
                         output bit pe_last);
    logic [7:0] p;
    logic       pe;
    for (int c = 0; c < 8; c++) hi[c] = 0;
    pe_cnt  = 0;
    pe_last = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      wr_en = 1'b0;
      p  = sel ? pwm_b : pwm_a;
      pe = sel ? pe_b : pe_a;
      for (int c = 0; c < 8; c++) hi[c] += int'(p[c]);
      pe_cnt += int'(pe);
      pe_last = pe;
      if (k == wr_at) begin
        wr_en   = 1'b1;
        wr_addr = wa;
        wr_data = wd;
      end
    end
  endtask

  initial begin
    int hi [8];
    int pe_cnt, n;
    bit pe_last;

    // 1: reset with enable high
    rst_n = 1'b0; enable = 1'b1; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 8'd0; rd_addr = 4'd0;
    push("rst_pwm_a", 32'h00); push("rst_rd_a", 32'h00); push("rst_pe_a", 32'h0);
    push("rst_pwm_b_pol", 32'hF0);
    repeat (2) @(negedge clk);
    pop_chk({24'd0, pwm_a}); pop_chk({24'd0, rd_data_a}); pop_chk({31'd0, pe_a});
    pop_chk({24'd0, pwm_b});

    // Duty programming while disabled; register read-back
    rst_n = 1'b1; enable = 1'b0;
    write(4'd0, 8'd64); write(4'd1, 8'd0); write(4'd2, 8'd255); write(4'd3, 8'd10);
    write(4'd7, 8'h5A); write(4'd12, 8'h33);
    read_chk("rd_ch7", 4'd7, 8'h5A);
    read_chk("rd_addr12", 4'd12, 8'h00);
    read_chk("rd_ch4_untouched", 4'd4, 8'h00);
    read_chk("rd_ch0", 4'd0, 8'd64);
    // Same-cycle write and read of ch5: old value first, new value next cycle
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'h77; rd_addr = 4'd5;
    push("rd_same_cycle_old", 32'h00);
    @(negedge clk);
    wr_en = 1'b0;
    pop_chk({24'd0, rd_data_a});
    push("rd_same_cycle_new", 32'h77);
    @(negedge clk);
    pop_chk({24'd0, rd_data_a});
    push("idle_pwm_a", 32'h00); push("idle_pwm_b", 32'hF0);
    pop_chk({24'd0, pwm_a}); pop_chk({24'd0, pwm_b});

    // 2/3: run, first period_end 255 cycles after enable
    enable = 1'b1;
    push("first_period_a", 32'd255);
    wait_pe(1'b0, 600, n);
    pop_chk(n);

    // W1: ch0=64, ch1=0, ch2=255, ch3=10
    push("w1_ch0_high", 32'd64); push("w1_ch0_low", 32'd191); push("w1_ch1", 32'd0);
    push("w1_ch2", 32'd255); push("w1_ch3", 32'd10); push("w1_pe_cnt", 32'd1);
    push("w1_pe_last", 32'd1);
    measure(1'b0, 255, -1, 4'd0, 8'd0, hi, pe_cnt, pe_last);
    pop_chk(hi[0]); pop_chk(255 - hi[0]); pop_chk(hi[1]); pop_chk(hi[2]); pop_chk(hi[3]);
    pop_chk(pe_cnt); pop_chk({31'd0, pe_last});

    // 4: write ch3=200 on the period_end cycle -> next period still 10
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'd200;
    push("w2_ch3_boundary_write", 32'd10); push("w2_ch1", 32'd0); push("w2_ch2", 32'd255);
    push("w2_pe_last", 32'd1);
    measure(1'b0, 255, -1, 4'd0, 8'd0, hi, pe_cnt, pe_last);
    pop_chk(hi[3]); pop_chk(hi[1]); pop_chk(hi[2]); pop_chk({31'd0, pe_last});

    // W3: 200 takes effect; mid-period write of 50 must not disturb it
    push("w3_ch3", 32'd200); push("w3_ch0", 32'd64); push("w3_pe_cnt", 32'd1);
    measure(1'b0, 255, 100, 4'd3, 8'd50, hi, pe_cnt, pe_last);
    pop_chk(hi[3]); pop_chk(hi[0]); pop_chk(pe_cnt);

    push("w4_ch3_mid_write", 32'd50); push("w4_ch2", 32'd255); push("w4_pe_last", 32'd1);
    measure(1'b0, 255, -1, 4'd0, 8'd0, hi, pe_cnt, pe_last);
    pop_chk(hi[3]); pop_chk(hi[2]); pop_chk({31'd0, pe_last});

    // 6: reset mid-period with enable high, then disabled
    repeat (100) @(negedge clk);
    rst_n = 1'b0; rd_addr = 4'd0;
    push("midrst_pwm_a", 32'h00); push("midrst_pwm_b", 32'hF0); push("midrst_pe_a", 32'h0);
    push("midrst_rd", 32'h00);
    @(negedge clk);
    pop_chk({24'd0, pwm_a}); pop_chk({24'd0, pwm_b}); pop_chk({31'd0, pe_a});
    pop_chk({24'd0, rd_data_a});
    rst_n = 1'b1; enable = 1'b0;
    read_chk("midrst_shadow_ch0", 4'd0, 8'h00);
    read_chk("midrst_shadow_ch3", 4'd3, 8'h00);
    push("dis_pwm_a", 32'h00); push("dis_pwm_b", 32'hF0); push("dis_pe_b", 32'h0);
    pop_chk({24'd0, pwm_a}); pop_chk({24'd0, pwm_b}); pop_chk({31'd0, pe_b});

    // PRESCALE=4 on u_b: period 1020 clk, duty 64 high for 256 clk, inverted idle channels
    write(4'd0, 8'd64);
    enable = 1'b1;
    push("first_period_b", 32'd1020);
    wait_pe(1'b1, 3000, n);
    pop_chk(n);
    push("b_ch0_high", 32'd256); push("b_ch1_zero", 32'd0); push("b_ch4_inv", 32'd1020);
    push("b_pe_cnt", 32'd1); push("b_pe_last", 32'd1);
    measure(1'b1, 1020, -1, 4'd0, 8'd0, hi, pe_cnt, pe_last);
    pop_chk(hi[0]); pop_chk(hi[1]); pop_chk(hi[4]); pop_chk(pe_cnt); pop_chk({31'd0, pe_last});

    // Enable dropped mid-period: idle next edge, restart from cnt=0 on re-enable
    repeat (100) @(negedge clk);
    enable = 1'b0;
    push("drop_pwm_b", 32'hF0); push("drop_pwm_a", 32'h00); push("drop_pe_b", 32'h0);
    @(negedge clk);
    pop_chk({24'd0, pwm_b}); pop_chk({24'd0, pwm_a}); pop_chk({31'd0, pe_b});
    enable = 1'b1;
    push("reenable_period_b", 32'd1020);
    wait_pe(1'b1, 3000, n);
    pop_chk(n);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
